// File: rtl/font_loader_pkg.sv
// Shared constants and state encoding for the glyph-load frame parser.
// FONT_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte to each frame.
package font_loader_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_SYNC = 2'd1;
    localparam logic [1:0] ERR_CSUM = 2'd2;

    typedef enum logic [2:0] {
        SYNC,
        CODE,
        ROWS,
        CSUM,
        COMMIT
    } loader_state_t;

endpackage

// File: rtl/char_font_loader.sv
// Parses SYNC/CODE/ROWS[/CSUM] frames, buffers one glyph and commits it row by row to font RAM.
// Define FONT_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte before commit.
module char_font_loader
    import font_loader_pkg::*;
#(
    parameter int CHAR_HORZ_PX_SIZE = 8,
    parameter int CHAR_VERT_PX_SIZE = 16,
    parameter int CHAR_VERT_PX_W    = $clog2(CHAR_VERT_PX_SIZE)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [7:0]                s_data,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic                      abort,
    output logic                      wr_en,
    output logic [7:0]                wr_char,
    output logic [CHAR_VERT_PX_W-1:0] wr_row,
    output logic [7:0]                wr_data,
    output logic                      busy,
    output logic                      load_done,
    output logic [1:0]                err_code
);

    if (CHAR_HORZ_PX_SIZE != 8) begin : g_bad_width
        $error("char_font_loader: CHAR_HORZ_PX_SIZE must be 8 (one byte per glyph row)");
    end

    localparam logic [CHAR_VERT_PX_W-1:0] LAST_ROW = CHAR_VERT_PX_W'(CHAR_VERT_PX_SIZE - 1);

    loader_state_t              state;
    logic [7:0]                 code_q;
    logic [CHAR_VERT_PX_W-1:0]  row_q;
    logic [7:0]                 glyph_buf [CHAR_VERT_PX_SIZE];
`ifdef FONT_LOADER_CHECKSUM_EN
    logic [7:0]                 csum_q;
`endif

    logic                       xfer;
    logic                       kill;
    logic                       buf_we;
    logic [7:0]                 first_row;
    logic [CHAR_VERT_PX_W-1:0]  next_row;

    assign xfer     = s_valid & s_ready;
    // abort only has meaning inside a frame; COMMIT is atomic and SYNC has nothing to drop.
    assign kill     = abort & ((state == CODE) | (state == ROWS) | (state == CSUM));
    assign buf_we   = xfer & ~kill & (state == ROWS);
    assign next_row = wr_row + CHAR_VERT_PX_W'(1);
    // A one-row glyph commits the byte that is being stored in the same cycle.
    assign first_row = ((state == ROWS) && (row_q == '0)) ? s_data : glyph_buf[0];

    always_ff @(posedge clk) begin
        if (buf_we) begin
            glyph_buf[row_q] <= s_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SYNC;
            s_ready   <= 1'b1;
            wr_en     <= 1'b0;
            wr_char   <= '0;
            wr_row    <= '0;
            wr_data   <= '0;
            busy      <= 1'b0;
            load_done <= 1'b0;
            err_code  <= ERR_NONE;
            code_q    <= '0;
            row_q     <= '0;
`ifdef FONT_LOADER_CHECKSUM_EN
            csum_q    <= '0;
`endif
        end else begin
            load_done <= 1'b0;
            err_code  <= ERR_NONE;
            if (kill) begin
                state <= SYNC;
                busy  <= 1'b0;
            end else begin
                case (state)
                    SYNC: begin
                        if (xfer) begin
                            if (s_data == SYNC_BYTE) begin
                                state <= CODE;
                                busy  <= 1'b1;
                            end else begin
                                err_code <= ERR_SYNC;
                            end
                        end
                    end
                    CODE: begin
                        if (xfer) begin
                            code_q <= s_data;
                            row_q  <= '0;
`ifdef FONT_LOADER_CHECKSUM_EN
                            csum_q <= s_data;
`endif
                            state  <= ROWS;
                        end
                    end
                    ROWS: begin
                        if (xfer) begin
                            row_q <= (row_q == LAST_ROW) ? '0 : row_q + CHAR_VERT_PX_W'(1);
`ifdef FONT_LOADER_CHECKSUM_EN
                            csum_q <= csum_q ^ s_data;
                            if (row_q == LAST_ROW) begin
                                state <= CSUM;
                            end
`else
                            if (row_q == LAST_ROW) begin
                                state   <= COMMIT;
                                s_ready <= 1'b0;
                                wr_en   <= 1'b1;
                                wr_char <= code_q;
                                wr_row  <= '0;
                                wr_data <= first_row;
                            end
`endif
                        end
                    end
                    CSUM: begin
`ifdef FONT_LOADER_CHECKSUM_EN
                        if (xfer) begin
                            if (s_data == csum_q) begin
                                state   <= COMMIT;
                                s_ready <= 1'b0;
                                wr_en   <= 1'b1;
                                wr_char <= code_q;
                                wr_row  <= '0;
                                wr_data <= first_row;
                            end else begin
                                err_code <= ERR_CSUM;
                                state    <= SYNC;
                                busy     <= 1'b0;
                            end
                        end
`else
                        state <= SYNC;
                        busy  <= 1'b0;
`endif
                    end
                    COMMIT: begin
                        if (wr_row == LAST_ROW) begin
                            wr_en     <= 1'b0;
                            state     <= SYNC;
                            load_done <= 1'b1;
                            s_ready   <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            wr_row  <= next_row;
                            wr_data <= glyph_buf[next_row];
                        end
                    end
                    default: begin
                        state   <= SYNC;
                        s_ready <= 1'b1;
                        wr_en   <= 1'b0;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
